// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control unit with memory wait states,
// latched N/Z/C flags for conditional jumps, and a resumable HALT state.
module cpu_sequencer #(
    parameter int IR_W          = 16,
    parameter int RA_W          = 3,
    parameter bit WAIT_EN       = 1'b1,
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] IR,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            mem_ready,
    input  logic            run,
    output logic [RA_W-1:0] w_adr,
    output logic [RA_W-1:0] r_adr,
    output logic [RA_W-1:0] s_adr,
    output logic            adr_sel,
    output logic            s_sel,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            pc_sel,
    output logic            ir_ld,
    output logic            mw_en,
    output logic            rw_en,
    output logic [3:0]      alu_op,
    output logic [2:0]      flags,
    output logic            illegal,
    output logic [7:0]      status
);
    localparam logic [4:0] S_RESET   = 5'd0;
    localparam logic [4:0] S_FETCH   = 5'd1;
    localparam logic [4:0] S_DECODE  = 5'd2;
    localparam logic [4:0] S_ADD     = 5'd3;
    localparam logic [4:0] S_SUB     = 5'd4;
    localparam logic [4:0] S_CMP     = 5'd5;
    localparam logic [4:0] S_MOV     = 5'd6;
    localparam logic [4:0] S_INC     = 5'd7;
    localparam logic [4:0] S_DEC     = 5'd8;
    localparam logic [4:0] S_SHL     = 5'd9;
    localparam logic [4:0] S_SHR     = 5'd10;
    localparam logic [4:0] S_LD      = 5'd11;
    localparam logic [4:0] S_STO     = 5'd12;
    localparam logic [4:0] S_LDI     = 5'd13;
    localparam logic [4:0] S_JE      = 5'd14;
    localparam logic [4:0] S_JNE     = 5'd15;
    localparam logic [4:0] S_JC      = 5'd16;
    localparam logic [4:0] S_JMP     = 5'd17;
    localparam logic [4:0] S_HALT    = 5'd18;
    localparam logic [4:0] S_ILLEGAL = 5'd31;

    logic [4:0] state, next_state, dec_state;
    logic [6:0] opcode;
    logic       rdy, taken, valid, alu_state;
    logic       unused_ir;

    assign opcode    = IR[IR_W-1 -: 7];
    assign rdy       = WAIT_EN ? mem_ready : 1'b1;
    assign valid     = (state >= S_FETCH && state <= S_HALT) || state == S_ILLEGAL;
    assign alu_state = state >= S_ADD && state <= S_SHR;
    assign unused_ir = ^IR;
    assign taken     = state == S_JMP || (state == S_JE && flags[1]) ||
                       (state == S_JNE && !flags[1]) || (state == S_JC && flags[0]);

    always_comb begin
        dec_state = S_ILLEGAL;
        if (opcode[6:4] == 3'b111)
            case (opcode[3:0])
                4'h0: dec_state = S_ADD;
                4'h1: dec_state = S_SUB;
                4'h2: dec_state = S_CMP;
                4'h3: dec_state = S_MOV;
                4'h4: dec_state = S_SHL;
                4'h5: dec_state = S_SHR;
                4'h6: dec_state = S_INC;
                4'h7: dec_state = S_DEC;
                4'h8: dec_state = S_LD;
                4'h9: dec_state = S_STO;
                4'hA: dec_state = S_LDI;
                4'hB: dec_state = S_HALT;
                4'hC: dec_state = S_JE;
                4'hD: dec_state = S_JNE;
                4'hE: dec_state = S_JC;
                default: dec_state = S_JMP;
            endcase
    end

    always_comb begin
        next_state = S_RESET;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: next_state = dec_state;
            S_ADD, S_SUB, S_CMP, S_MOV, S_INC, S_DEC, S_SHL, S_SHR:
                next_state = S_FETCH;
            S_LD, S_STO, S_LDI, S_JE, S_JNE, S_JC, S_JMP:
                next_state = rdy ? S_FETCH : state;
            S_HALT:    next_state = run ? S_FETCH : S_HALT;
            S_ILLEGAL: next_state = ILLEGAL_HALTS ? S_HALT : S_FETCH;
            default:   next_state = S_RESET;
        endcase
    end

    always_comb begin
        w_adr   = valid ? IR[2*RA_W-1:RA_W] : '0;
        r_adr   = w_adr;
        s_adr   = valid ? IR[RA_W-1:0] : '0;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_sel  = 1'b0;
        ir_ld   = 1'b0;
        mw_en   = 1'b0;
        rw_en   = 1'b0;
        alu_op  = 4'd0;
        status  = state == S_RESET ? 8'hFF : {flags, state};
        case (state)
            S_FETCH: begin
                ir_ld  = rdy;
                pc_inc = rdy;
            end
            S_ADD: begin rw_en = 1'b1; alu_op = 4'd1; end
            S_SUB: begin rw_en = 1'b1; alu_op = 4'd2; end
            S_CMP: alu_op = 4'd2;
            S_MOV: rw_en = 1'b1;
            S_SHL: begin rw_en = 1'b1; alu_op = 4'd3; end
            S_SHR: begin rw_en = 1'b1; alu_op = 4'd4; end
            S_INC: begin rw_en = 1'b1; alu_op = 4'd5; end
            S_DEC: begin rw_en = 1'b1; alu_op = 4'd6; end
            S_LD: begin
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                rw_en   = rdy;
            end
            S_STO: begin
                adr_sel = 1'b1;
                mw_en   = 1'b1;
            end
            S_LDI: begin
                s_sel  = 1'b1;
                rw_en  = rdy;
                pc_inc = rdy;
            end
            S_JE, S_JNE, S_JC, S_JMP: begin
                pc_ld  = rdy && taken;
                pc_sel = rdy && taken;
                pc_inc = rdy && !taken;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= S_RESET;
            flags   <= 3'b000;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (alu_state)
                flags <= {N, Z, C};
            if (state == S_ILLEGAL)
                illegal <= 1'b1;
        end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-vector bench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;
    logic        clk, reset;
    logic [15:0] IR;
    logic        N, Z, C, mem_ready, run;
    logic [2:0]  w_adr, r_adr, s_adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
    logic [3:0]  alu_op;
    logic [2:0]  flags;
    logic        illegal;
    logic [7:0]  status;
    int          errors = 0;
    int          checks = 0;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .C(C),
        .mem_ready(mem_ready), .run(run),
        .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .ir_ld(ir_ld), .mw_en(mw_en), .rw_en(rw_en),
        .alu_op(alu_op), .flags(flags), .illegal(illegal), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; IR = 16'hE00A; N = 0; Z = 0; C = 0; mem_ready = 1'b1; run = 1'b0;
        #12;
        check("rst_status", status, 8'hFF);
        check("rst_flags", {5'd0, flags}, 8'h00);
        check("rst_strobes", {ir_ld, pc_inc, pc_ld, rw_en, mw_en, adr_sel, s_sel, pc_sel}, 8'h00);
        @(negedge clk) reset = 1'b0;
        #1 check("reset_state", status, 8'hFF);
        tick();
        check("fetch_status", status, 8'h01);
        check("fetch_strobes", {6'd0, ir_ld, pc_inc}, 8'h03);
        tick();
        check("decode_status", status, 8'h02);
        check("decode_strobes", {ir_ld, pc_inc, pc_ld, rw_en, mw_en, adr_sel, s_sel, pc_sel}, 8'h00);
        C = 1'b1;
        tick();
        check("add_state", {3'd0, status[4:0]}, 8'd3);
        check("add_alu_op", {4'd0, alu_op}, 8'd1);
        check("add_rw_en", {7'd0, rw_en}, 8'd1);
        check("add_w_adr", {5'd0, w_adr}, 8'd1);
        check("add_r_adr", {5'd0, r_adr}, 8'd1);
        check("add_s_adr", {5'd0, s_adr}, 8'd2);
        tick();
        check("add_flags_status", status, 8'h21);
        IR = 16'hE400;
        C = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("fwait_state", {3'd0, status[4:0]}, 8'd1);
            check("fwait_ir_ld", {7'd0, ir_ld}, {7'd0, i == 3});
            check("fwait_pc_inc", {7'd0, pc_inc}, {7'd0, i == 3});
            tick();
        end
        check("fwait_decode", {3'd0, status[4:0]}, 8'd2);
        Z = 1'b1;
        tick();
        check("cmp_state", {3'd0, status[4:0]}, 8'd5);
        check("cmp_alu_op", {4'd0, alu_op}, 8'd2);
        check("cmp_rw_en", {7'd0, rw_en}, 8'd0);
        tick();
        Z = 1'b0;
        check("cmp_flags", {5'd0, flags}, 8'h02);
        IR = 16'hF800;
        tick();
        tick();
        check("je_state", {3'd0, status[4:0]}, 8'd14);
        check("je_pc", {5'd0, pc_ld, pc_sel, pc_inc}, 8'b110);
        tick();
        IR = 16'hFA00;
        tick();
        tick();
        check("jne_state", {3'd0, status[4:0]}, 8'd15);
        check("jne_pc", {5'd0, pc_ld, pc_sel, pc_inc}, 8'b001);
        tick();
        IR = 16'hF200;
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            check("sto_state", {3'd0, status[4:0]}, 8'd12);
            check("sto_mw_en", {7'd0, mw_en}, 8'd1);
            check("sto_adr_sel", {7'd0, adr_sel}, 8'd1);
            tick();
        end
        check("sto_exit", {3'd0, status[4:0]}, 8'd1);
        check("sto_exit_mw_en", {7'd0, mw_en}, 8'd0);
        IR = 16'h0000;
        tick();
        tick();
        check("illegal_state", {3'd0, status[4:0]}, 8'd31);
        tick();
        check("halt_state", {3'd0, status[4:0]}, 8'd18);
        check("halt_illegal", {7'd0, illegal}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_hold", {3'd0, status[4:0]}, 8'd18);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        check("run_fetch", {3'd0, status[4:0]}, 8'd1);
        check("run_illegal", {7'd0, illegal}, 8'd1);
        IR = 16'hF400;
        tick();
        mem_ready = 1'b0;
        tick();
        check("ldi_state", {3'd0, status[4:0]}, 8'd13);
        check("ldi_wait", {6'd0, s_sel, rw_en}, 8'b10);
        tick();
        #1 reset = 1'b1;
        #1;
        check("mid_rst_status", status, 8'hFF);
        check("mid_rst_strobes", {ir_ld, pc_inc, pc_ld, rw_en, mw_en, adr_sel, s_sel, pc_sel}, 8'h00);
        check("mid_rst_flags", {5'd0, flags}, 8'h00);
        check("mid_rst_illegal", {7'd0, illegal}, 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
